// File: rtl/fdivsqrt_seq.sv
// Sequencing controller for the divide/square-root unit: accept, optional subnormal
// normalization, format-dependent iteration count, done hold. Build option: FDIVSQRT_EARLYTERM_EN.
module fdivsqrt_seq #(
  parameter int CNTW  = 6,
  parameter int CYC_H = 4,
  parameter int CYC_S = 7,
  parameter int CYC_D = 14,
  parameter int CYC_Q = 29
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       FDivStartE,
  input  logic [1:0] FmtE,
  input  logic       SqrtE,
  input  logic       SpecialCaseE,
  input  logic       XSubnormE,
  input  logic       YSubnormE,
  input  logic       WZeroE,
  input  logic       FlushE,
  input  logic       StallM,
  output logic       FDivBusyE,
  output logic       FDivDoneE,
  output logic       ExpLoadE,
  output logic       NormEnE,
  output logic       IterEnE,
  output logic       EarlyTermE
);

  typedef enum logic [1:0] {IDLE, NORM, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [CNTW-1:0] cnt, cnt_nxt;
  logic [CNTW-1:0] cyc_m1;
  logic            armed;
  logic            accept;
  logic            et_set;

  // Load value is one less than the iteration count: BUSY exits on cnt==0.
  always_comb begin
    case (FmtE)
      2'b00:   cyc_m1 = CNTW'(CYC_S - 1);
      2'b01:   cyc_m1 = CNTW'(CYC_D - 1);
      2'b10:   cyc_m1 = CNTW'(CYC_H - 1);
      2'b11:   cyc_m1 = CNTW'(CYC_Q - 1);
      default: cyc_m1 = CNTW'(CYC_S - 1);
    endcase
  end

  // armed stays low for the first cycle after reset release so no start is taken then.
  assign accept = (state == IDLE) & armed & FDivStartE & ~FlushE;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ExpLoadE  = 1'b0;
    NormEnE   = 1'b0;
    IterEnE   = 1'b0;
    FDivDoneE = 1'b0;
    FDivBusyE = 1'b0;
    et_set    = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          ExpLoadE  = 1'b1;
          cnt_nxt   = cyc_m1;
          FDivBusyE = ~SpecialCaseE;
          if (SpecialCaseE)
            state_nxt = DONE;
          else if (XSubnormE | (YSubnormE & ~SqrtE))
            state_nxt = NORM;
          else
            state_nxt = BUSY;
        end
      end
      NORM: begin
        NormEnE   = 1'b1;
        FDivBusyE = 1'b1;
        state_nxt = BUSY;
      end
      BUSY: begin
        IterEnE   = 1'b1;
        FDivBusyE = 1'b1;
        if (cnt == '0) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - CNTW'(1);
`ifdef FDIVSQRT_EARLYTERM_EN
          if (WZeroE) begin
            state_nxt = DONE;
            et_set    = 1'b1;
          end
`endif
        end
      end
      DONE: begin
        FDivDoneE = 1'b1;
        if (~StallM)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Flush aborts from any state and suppresses every datapath enable this cycle.
    if (FlushE) begin
      state_nxt = IDLE;
      ExpLoadE  = 1'b0;
      NormEnE   = 1'b0;
      IterEnE   = 1'b0;
      et_set    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      armed <= 1'b1;
    end
  end

`ifdef FDIVSQRT_EARLYTERM_EN
  logic et_flag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      et_flag <= 1'b0;
    else if (FlushE | ((state == DONE) & (state_nxt != DONE)))
      et_flag <= 1'b0;
    else if (et_set)
      et_flag <= 1'b1;
  end

  assign EarlyTermE = et_flag & (state == DONE);
`else
  logic unused_early;
  assign unused_early = WZeroE | et_set;
  assign EarlyTermE   = 1'b0;
`endif

endmodule

// File: tb/tb_fdivsqrt_seq.sv
// Self-checking bench for fdivsqrt_seq: directed schedule checks plus randomized stimulus
// compared every cycle against a cycle-count based behavioural model.
module tb_fdivsqrt_seq;

  localparam int CYC_H = 4;
  localparam int CYC_S = 7;
  localparam int CYC_D = 14;
  localparam int CYC_Q = 29;
`ifdef FDIVSQRT_EARLYTERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       FDivStartE = 1'b0;
  logic [1:0] FmtE = 2'b00;
  logic       SqrtE = 1'b0;
  logic       SpecialCaseE = 1'b0;
  logic       XSubnormE = 1'b0;
  logic       YSubnormE = 1'b0;
  logic       WZeroE = 1'b0;
  logic       FlushE = 1'b0;
  logic       StallM = 1'b0;
  logic       FDivBusyE, FDivDoneE, ExpLoadE, NormEnE, IterEnE, EarlyTermE;

  int errors = 0;
  int checks = 0;

  fdivsqrt_seq #(.CNTW(6), .CYC_H(CYC_H), .CYC_S(CYC_S), .CYC_D(CYC_D), .CYC_Q(CYC_Q)) dut (
    .clk(clk), .reset(reset), .FDivStartE(FDivStartE), .FmtE(FmtE), .SqrtE(SqrtE),
    .SpecialCaseE(SpecialCaseE), .XSubnormE(XSubnormE), .YSubnormE(YSubnormE),
    .WZeroE(WZeroE), .FlushE(FlushE), .StallM(StallM), .FDivBusyE(FDivBusyE),
    .FDivDoneE(FDivDoneE), .ExpLoadE(ExpLoadE), .NormEnE(NormEnE), .IterEnE(IterEnE),
    .EarlyTermE(EarlyTermE)
  );

  always #5 clk = ~clk;

  function automatic int cyc_of(input logic [1:0] f);
    case (f)
      2'b00:   return CYC_S;
      2'b01:   return CYC_D;
      2'b10:   return CYC_H;
      default: return CYC_Q;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Model: an accepted operation is tracked by k = cycles since accept; norm, iteration
  // and done windows follow from k, the subnormal flag and the format's cycle count.
  initial begin : model
    int mode, k, cyc, first, last;
    bit sub, et, fresh;
    logic b, d, l, n, it, e;
    logic [5:0] exp_v, act_v;
    mode = 0; k = 0; cyc = 0; sub = 0; et = 0; fresh = 1;
    forever begin
      @(negedge clk);
      b = 0; d = 0; l = 0; n = 0; it = 0; e = 0;
      if (reset) begin
        mode = 0; fresh = 1; et = 0;
      end else if (fresh) begin
        fresh = 0; mode = 0;
      end else if (mode == 0) begin
        if (FDivStartE && !FlushE) begin
          l = 1; b = !SpecialCaseE;
          if (SpecialCaseE) begin
            mode = 2; et = 0;
          end else begin
            mode = 1; k = 1;
            sub = XSubnormE || (YSubnormE && !SqrtE);
            cyc = cyc_of(FmtE);
          end
        end
      end else if (mode == 1) begin
        first = sub ? 2 : 1;
        last  = cyc + (sub ? 1 : 0);
        b  = 1;
        n  = sub && (k == 1) && !FlushE;
        it = (k >= first) && !FlushE;
        if (FlushE) mode = 0;
        else if (k == last) begin mode = 2; et = 0; end
        else if (ET && (k >= first) && WZeroE) begin mode = 2; et = 1; end
        else k++;
      end else begin
        d = 1; e = et;
        if (FlushE || !StallM) begin mode = 0; et = 0; end
      end
      exp_v = {b, d, l, n, it, e};
      act_v = {FDivBusyE, FDivDoneE, ExpLoadE, NormEnE, IterEnE, EarlyTermE};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cycle t=%0t: {busy,done,load,norm,iter,et} got %b, expected %b",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic idle_inputs();
    FDivStartE = 0; FlushE = 0; StallM = 0; WZeroE = 0; SpecialCaseE = 0;
    XSubnormE = 0; YSubnormE = 0; SqrtE = 0;
  endtask

  // Drives one start at c=0 and scripted control, tallying output activity per cycle.
  task automatic direct(input logic [1:0] fmt, input bit sq, input bit sp, input bit xs,
                        input bit ys, input int stall_lo, input int stall_hi,
                        input int flush_at, input int restart_at, input int wz_at,
                        input int ncyc, output int first_done, output int n_iter,
                        output int n_done, output int n_busy, output int norm_at,
                        output int n_load, output int n_et);
    first_done = -1; n_iter = 0; n_done = 0; n_busy = 0; norm_at = -1; n_load = 0; n_et = 0;
    for (int c = 0; c < ncyc; c++) begin
      FDivStartE = (c == 0) || (c == restart_at);
      FmtE = fmt; SqrtE = sq; SpecialCaseE = sp; XSubnormE = xs; YSubnormE = ys;
      FlushE = (c == flush_at);
      StallM = (c >= stall_lo) && (c <= stall_hi);
      WZeroE = (c == wz_at);
      @(negedge clk);
      if (FDivDoneE && first_done < 0) first_done = c;
      if (IterEnE) n_iter++;
      if (FDivDoneE) n_done++;
      if (FDivBusyE) n_busy++;
      if (NormEnE && norm_at < 0) norm_at = c;
      if (ExpLoadE) n_load++;
      if (EarlyTermE) n_et++;
      @(posedge clk); #1;
    end
    idle_inputs();
  endtask

  initial begin : main
    int fd, ni, nd, nb, na, nl, ne;
    @(negedge clk);
    chk("reset_outputs", {FDivBusyE, FDivDoneE, ExpLoadE, NormEnE, IterEnE, EarlyTermE}, 0);
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;

    direct(2'b01, 0, 0, 0, 0, -1, -1, -1, -1, -1, 18, fd, ni, nd, nb, na, nl, ne);
    chk("d_div_done_at", fd, 15); chk("d_div_iters", ni, 14);
    chk("d_div_done_cnt", nd, 1); chk("d_div_busy_cnt", nb, 15); chk("d_div_load", nl, 1);

    direct(2'b00, 1, 0, 1, 1, -1, -1, -1, -1, -1, 12, fd, ni, nd, nb, na, nl, ne);
    chk("s_sqrt_sub_norm_at", na, 1); chk("s_sqrt_sub_iters", ni, 7);
    chk("s_sqrt_sub_done_at", fd, 9);

    direct(2'b00, 1, 0, 0, 1, -1, -1, -1, -1, -1, 11, fd, ni, nd, nb, na, nl, ne);
    chk("s_sqrt_ysub_norm", na, -1); chk("s_sqrt_ysub_done_at", fd, 8);

    direct(2'b11, 0, 1, 0, 0, -1, -1, -1, -1, -1, 4, fd, ni, nd, nb, na, nl, ne);
    chk("special_iters", ni, 0); chk("special_busy", nb, 0); chk("special_done_at", fd, 1);

    direct(2'b11, 0, 0, 0, 0, -1, -1, 5, -1, -1, 6, fd, ni, nd, nb, na, nl, ne);
    chk("q_flush_done", nd, 0); chk("q_flush_iters", ni, 4);
    direct(2'b10, 0, 0, 0, 0, -1, -1, -1, -1, -1, 8, fd, ni, nd, nb, na, nl, ne);
    chk("after_flush_load", nl, 1); chk("after_flush_done_at", fd, 5);

    direct(2'b10, 0, 0, 0, 0, 5, 7, -1, 6, -1, 12, fd, ni, nd, nb, na, nl, ne);
    chk("h_stall_done_at", fd, 5); chk("h_stall_done_cnt", nd, 4); chk("h_stall_load", nl, 1);

    direct(2'b01, 0, 0, 0, 0, -1, -1, -1, -1, 3, 18, fd, ni, nd, nb, na, nl, ne);
`ifdef FDIVSQRT_EARLYTERM_EN
    chk("et_done_at", fd, 4); chk("et_flag", ne, 1); chk("et_iters", ni, 3);
`else
    chk("et_done_at", fd, 15); chk("et_flag", ne, 0); chk("et_iters", ni, 14);
`endif

    direct(2'b01, 0, 0, 0, 0, -1, -1, -1, -1, -1, 7, fd, ni, nd, nb, na, nl, ne);
    FmtE = 2'b01;
    reset = 1;
    @(negedge clk);
    chk("reset_mid_op", {FDivBusyE, FDivDoneE, ExpLoadE, NormEnE, IterEnE, EarlyTermE}, 0);
    @(posedge clk); #1;
    reset = 0;
    FDivStartE = 1;
    @(negedge clk);
    chk("release_cycle", {FDivBusyE, FDivDoneE, ExpLoadE, NormEnE, IterEnE, EarlyTermE}, 0);
    @(posedge clk); #1;
    direct(2'b01, 0, 0, 0, 0, -1, -1, -1, -1, -1, 17, fd, ni, nd, nb, na, nl, ne);
    chk("post_reset_done_at", fd, 15);

    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 299) == 0);
      FDivStartE   = ($urandom_range(0, 2) == 0);
      FmtE         = 2'($urandom_range(0, 3));
      SqrtE        = 1'($urandom_range(0, 1));
      SpecialCaseE = ($urandom_range(0, 5) == 0);
      XSubnormE    = ($urandom_range(0, 3) == 0);
      YSubnormE    = ($urandom_range(0, 3) == 0);
      WZeroE       = ($urandom_range(0, 7) == 0);
      FlushE       = ($urandom_range(0, 39) == 0);
      StallM       = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    reset = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
